// File: rtl/cv32e40p_alu_tmr_voter.sv
// 2-of-3 voter for the triplicated ALU, with per-replica fault masking (DMR) and a sticky fatal flag.
// Optional saturating error-event counter when CV32E40P_TMR_ERR_CNT_EN is defined.
//   state | meaning
//   TMR   | all three replicas voted bitwise
//   DMRk  | replica k excluded, lowest remaining replica forwarded
//   FAIL  | uncorrectable disagreement seen, best-effort majority forwarded
module cv32e40p_alu_tmr_voter #(
  parameter int unsigned THRESH = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        ex_ready_i,
  input  logic        clear_i,
  input  logic [31:0] result_1_i,
  input  logic [31:0] result_2_i,
  input  logic [31:0] result_3_i,
  input  logic        cmp_1_i,
  input  logic        cmp_2_i,
  input  logic        cmp_3_i,
  input  logic        ready_1_i,
  input  logic        ready_2_i,
  input  logic        ready_3_i,
  output logic [31:0] result_o,
  output logic        comparison_result_o,
  output logic        ready_o,
  output logic        corrected_o,
  output logic [1:0]  masked_id_o,
  output logic        fatal_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [2:0] {S_TMR, S_DMR1, S_DMR2, S_DMR3, S_FAIL} state_t;

  localparam logic [CNT_W-1:0] LP_THRESH = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

  state_t                  r_state, w_state_nxt;
  logic [2:0][CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                    r_corrected, w_corr_nxt;

  logic [2:0][31:0] w_res;
  logic [2:0]       w_cmp, w_rdy;
  logic [31:0]      w_maj_res, w_res_v;
  logic             w_maj_cmp, w_maj_rdy, w_cmp_v, w_rdy_v;
  logic [2:0]       w_mis, w_full;
  logic [1:0]       w_n_mis;
  logic             w_all_diff, w_pair_diff, w_consume;

  assign w_res = {result_3_i, result_2_i, result_1_i};
  assign w_cmp = {cmp_3_i, cmp_2_i, cmp_1_i};
  assign w_rdy = {ready_3_i, ready_2_i, ready_1_i};

  assign w_maj_res = (w_res[0] & w_res[1]) | (w_res[0] & w_res[2]) | (w_res[1] & w_res[2]);
  assign w_maj_cmp = (w_cmp[0] & w_cmp[1]) | (w_cmp[0] & w_cmp[2]) | (w_cmp[1] & w_cmp[2]);
  assign w_maj_rdy = (w_rdy[0] & w_rdy[1]) | (w_rdy[0] & w_rdy[2]) | (w_rdy[1] & w_rdy[2]);

  always_comb begin
    w_res_v = w_maj_res;
    w_cmp_v = w_maj_cmp;
    w_rdy_v = w_maj_rdy;
    case (r_state)
      S_DMR1: begin
        w_res_v = w_res[1];
        w_cmp_v = w_cmp[1];
        w_rdy_v = w_rdy[1];
      end
      S_DMR2, S_DMR3: begin
        w_res_v = w_res[0];
        w_cmp_v = w_cmp[0];
        w_rdy_v = w_rdy[0];
      end
      default: ;
    endcase
  end

  assign result_o            = w_res_v;
  assign comparison_result_o = w_cmp_v;
  assign ready_o             = w_rdy_v;

  always_comb begin
    w_mis = '0;
    for (int i = 0; i < 3; i++) begin
      w_mis[i] = (w_res[i] != w_res_v) | (w_cmp[i] != w_cmp_v) | (w_rdy[i] != w_rdy_v);
    end
  end

  assign w_n_mis    = {1'b0, w_mis[0]} + {1'b0, w_mis[1]} + {1'b0, w_mis[2]};
  assign w_all_diff = (w_res[0] != w_res[1]) && (w_res[0] != w_res[2]) && (w_res[1] != w_res[2]);
  assign w_consume  = enable_i & ready_o & ex_ready_i;

  // Disagreement within the surviving pair while one replica is masked.
  always_comb begin
    w_pair_diff = 1'b0;
    case (r_state)
      S_DMR1: w_pair_diff = (w_res[1] != w_res[2]) | (w_cmp[1] != w_cmp[2]) | (w_rdy[1] != w_rdy[2]);
      S_DMR2: w_pair_diff = (w_res[0] != w_res[2]) | (w_cmp[0] != w_cmp[2]) | (w_rdy[0] != w_rdy[2]);
      S_DMR3: w_pair_diff = (w_res[0] != w_res[1]) | (w_cmp[0] != w_cmp[1]) | (w_rdy[0] != w_rdy[1]);
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_corr_nxt  = 1'b0;
    w_full      = '0;
    if (clear_i) begin
      w_state_nxt = S_TMR;
      w_cnt_nxt   = '0;
    end else if (w_consume) begin
      case (r_state)
        S_TMR: begin
          if (w_n_mis >= 2'd2 || w_all_diff) begin
            w_state_nxt = S_FAIL;
          end else if (w_n_mis == 2'd0) begin
            w_cnt_nxt = '0;
          end else begin
            w_corr_nxt = 1'b1;
            for (int i = 0; i < 3; i++) begin
              if (w_mis[i]) begin
                w_cnt_nxt[i] = (r_cnt[i] >= LP_THRESH) ? LP_THRESH : r_cnt[i] + LP_ONE;
              end else begin
                w_cnt_nxt[i] = '0;
              end
              w_full[i] = (w_cnt_nxt[i] == LP_THRESH);
            end
            case (w_full)
              3'b000:  ;
              3'b001:  w_state_nxt = S_DMR1;
              3'b010:  w_state_nxt = S_DMR2;
              3'b100:  w_state_nxt = S_DMR3;
              default: begin
                w_state_nxt = S_FAIL;
                w_corr_nxt  = 1'b0;
              end
            endcase
          end
        end
        S_DMR1, S_DMR2, S_DMR3: begin
          if (w_pair_diff) w_state_nxt = S_FAIL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_TMR;
      r_cnt       <= '0;
      r_corrected <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_corrected <= w_corr_nxt;
    end
  end

  assign corrected_o = r_corrected;
  assign fatal_o     = (r_state == S_FAIL);

  always_comb begin
    masked_id_o = 2'd0;
    case (r_state)
      S_DMR1:  masked_id_o = 2'd1;
      S_DMR2:  masked_id_o = 2'd2;
      S_DMR3:  masked_id_o = 2'd3;
      default: ;
    endcase
  end

`ifdef CV32E40P_TMR_ERR_CNT_EN
  logic        w_any_mis;
  logic [15:0] r_err_cnt;

  // In DMR the ignored replica never counts; only the surviving pair does.
  assign w_any_mis = (r_state == S_DMR1 || r_state == S_DMR2 || r_state == S_DMR3) ?
                     w_pair_diff : (|w_mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (clear_i) begin
      r_err_cnt <= '0;
    end else if (w_consume && w_any_mis && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_cv32e40p_alu_tmr_voter.sv
// Bench for the ALU TMR voter: directed vector table, hand-written reset sequence,
// then randomized traffic checked against a behavioural vote/mask model.
module tb_cv32e40p_alu_tmr_voter;

  localparam int THRESH = 4;
  localparam logic [31:0] A = 32'h1234_5678;
  localparam logic [31:0] B = 32'h1234_5679;
  localparam logic [31:0] C = 32'h1234_567A;
  localparam logic [31:0] G = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0, ex_ready_i = 1'b0, clear_i = 1'b0;
  logic [31:0] result_1_i = '0, result_2_i = '0, result_3_i = '0;
  logic        cmp_1_i = 1'b0, cmp_2_i = 1'b0, cmp_3_i = 1'b0;
  logic        ready_1_i = 1'b0, ready_2_i = 1'b0, ready_3_i = 1'b0;
  logic [31:0] result_o;
  logic        comparison_result_o, ready_o, corrected_o, fatal_o;
  logic [1:0]  masked_id_o;
  logic [15:0] err_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cv32e40p_alu_tmr_voter #(.THRESH(THRESH), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .ex_ready_i(ex_ready_i), .clear_i(clear_i),
    .result_1_i(result_1_i), .result_2_i(result_2_i), .result_3_i(result_3_i),
    .cmp_1_i(cmp_1_i), .cmp_2_i(cmp_2_i), .cmp_3_i(cmp_3_i),
    .ready_1_i(ready_1_i), .ready_2_i(ready_2_i), .ready_3_i(ready_3_i),
    .result_o(result_o), .comparison_result_o(comparison_result_o), .ready_o(ready_o),
    .corrected_o(corrected_o), .masked_id_o(masked_id_o), .fatal_o(fatal_o),
    .err_cnt_o(err_cnt_o)
  );

  typedef struct {
    logic [31:0] r1, r2, r3;
    logic [2:0]  cmp, rdy;
    logic        en, exr, clr;
    logic [31:0] e_res;
    logic        e_cmp, e_rdy, e_corr;
    logic [1:0]  e_mask;
    logic        e_fat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [31:0] r1, logic [31:0] r2, logic [31:0] r3,
                              logic [2:0] cmp, logic [2:0] rdy, logic en, logic exr, logic clr,
                              logic [31:0] e_res, logic e_cmp, logic e_rdy,
                              logic e_corr, logic [1:0] e_mask, logic e_fat);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.r3 = r3; v.cmp = cmp; v.rdy = rdy;
    v.en = en; v.exr = exr; v.clr = clr;
    v.e_res = e_res; v.e_cmp = e_cmp; v.e_rdy = e_rdy;
    v.e_corr = e_corr; v.e_mask = e_mask; v.e_fat = e_fat;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic apply(logic [31:0] r1, logic [31:0] r2, logic [31:0] r3,
                       logic [2:0] cmp, logic [2:0] rdy, logic en, logic exr, logic clr);
    @(negedge clk);
    result_1_i = r1; result_2_i = r2; result_3_i = r3;
    {cmp_3_i, cmp_2_i, cmp_1_i}       = cmp;
    {ready_3_i, ready_2_i, ready_1_i} = rdy;
    enable_i = en; ex_ready_i = exr; clear_i = clr;
    #1;
  endtask

  // Behavioural reference: mask index (0 = none), failure flag, streak per replica.
  int m_mask;
  bit m_fail;
  bit m_corr;
  int m_cnt[3];

  function automatic logic [31:0] maj_word(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mask = 0; m_fail = 0; m_corr = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic run_random(int cycles);
    int f, fprob;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      logic [31:0] base, r[3], v_res;
      logic        bc, v_cmp, v_rdy;
      logic [2:0]  cmp, rdy;
      logic        en, exr, clr;
      int          nm, k, src;
      bit          mis[3];
      if (cyc % 100 == 0) begin
        f = $urandom_range(0, 2);
        case ($urandom_range(0, 3))
          0: fprob = 0;
          1: fprob = 20;
          2: fprob = 70;
          default: fprob = 100;
        endcase
      end
      base = $urandom;
      bc   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
        r[i] = base; cmp[i] = bc; rdy[i] = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
      end
      rdy = {3{rdy[0]}};
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 99) < ((i == f) ? fprob : 4)) begin
          case ($urandom_range(0, 3))
            0: cmp[i] = ~cmp[i];
            1: rdy[i] = ~rdy[i];
            default: r[i] = r[i] ^ (32'h1 << $urandom_range(0, 31));
          endcase
        end
      end
      en  = ($urandom_range(0, 9) != 0);
      exr = ($urandom_range(0, 9) < 8);
      clr = m_fail ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
      apply(r[0], r[1], r[2], cmp, rdy, en, exr, clr);

      if (m_mask == 0) begin
        v_res = maj_word(r[0], r[1], r[2]);
        v_cmp = (int'(cmp[0]) + int'(cmp[1]) + int'(cmp[2])) >= 2;
        v_rdy = (int'(rdy[0]) + int'(rdy[1]) + int'(rdy[2])) >= 2;
      end else begin
        src = (m_mask == 1) ? 1 : 0;
        v_res = r[src]; v_cmp = cmp[src]; v_rdy = rdy[src];
      end
      chk("rnd_result", result_o, v_res);
      chk("rnd_cmp", 32'(comparison_result_o), 32'(v_cmp));
      chk("rnd_ready", 32'(ready_o), 32'(v_rdy));
      chk("rnd_corrected", 32'(corrected_o), 32'(m_corr));
      chk("rnd_masked", 32'(masked_id_o), 32'(m_mask));
      chk("rnd_fatal", 32'(fatal_o), 32'(m_fail));

      m_corr = 0;
      if (clr) begin
        model_reset();
      end else if (en && v_rdy && exr && !m_fail) begin
        if (m_mask == 0) begin
          nm = 0; k = 0;
          for (int i = 0; i < 3; i++) begin
            mis[i] = (r[i] != v_res) || (cmp[i] != v_cmp) || (rdy[i] != v_rdy);
            if (mis[i]) begin nm++; k = i; end
          end
          if (nm >= 2 || (r[0] != r[1] && r[0] != r[2] && r[1] != r[2])) begin
            m_fail = 1;
          end else if (nm == 1) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = (i == k) ? m_cnt[i] + 1 : 0;
            if (m_cnt[k] > THRESH) m_cnt[k] = THRESH;
            m_corr = 1;
            if (m_cnt[k] == THRESH) m_mask = k + 1;
          end else begin
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
          end
        end else begin
          int a, b;
          a = (m_mask == 1) ? 1 : 0;
          b = (m_mask == 3) ? 1 : 2;
          if (r[a] != r[b] || cmp[a] != cmp[b] || rdy[a] != rdy[b]) begin
            m_fail = 1;
            m_mask = 0;
          end
        end
      end
    end
  endtask

  initial begin
    // Directed table: expected flags are those visible while the vector is applied.
    tbl.push_back(mk(A, A, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 0, 0, 0));
    tbl.push_back(mk(A, B, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 0, 0, 0));
    tbl.push_back(mk(A, A, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 1, 0, 0));
    tbl.push_back(mk(A, A, B, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(A, A, B, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 1, 0, 0));
    tbl.push_back(mk(A, A, G, 3'b011, 3'b011, 1, 1, 0, A, 1, 1, 1, 3, 0));
    tbl.push_back(mk(A, A, G, 3'b011, 3'b011, 1, 1, 0, A, 1, 1, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 3'b111, 3'b111, 1, 1, 0, 0, 1, 1, 0, 3, 0));
    tbl.push_back(mk(5, 5, 5, 3'b111, 3'b111, 1, 1, 0, 5, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3, 3'b111, 3'b111, 1, 1, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(A, A, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 0, 0, 0));
    // Build replica-2 streak to 3, stall 10 cycles, then one more consume masks it.
    tbl.push_back(mk(A, B, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 0, 0, 0));
    tbl.push_back(mk(A, B, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 1, 0, 0));
    tbl.push_back(mk(A, B, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 1, 0, 0));
    tbl.push_back(mk(A, B, A, 3'b111, 3'b111, 1, 0, 0, A, 1, 1, 1, 0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(A, B, A, 3'b111, 3'b111, 1, 0, 0, A, 1, 1, 0, 0, 0));
    tbl.push_back(mk(A, B, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 0, 0, 0));
    tbl.push_back(mk(A, 0, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 1, 2, 0));
    tbl.push_back(mk(0, A, 1, 3'b111, 3'b111, 0, 1, 0, 0, 1, 1, 0, 2, 0));
    tbl.push_back(mk(0, A, 1, 3'b111, 3'b110, 1, 1, 0, 0, 1, 0, 0, 2, 0));
    tbl.push_back(mk(A, A, A, 3'b111, 3'b111, 1, 1, 1, A, 1, 1, 0, 2, 0));
    tbl.push_back(mk(A, B, C, 3'b111, 3'b111, 1, 1, 1, A, 1, 1, 0, 0, 0));
    tbl.push_back(mk(A, A, A, 3'b111, 3'b011, 1, 1, 0, A, 1, 1, 0, 0, 0));
    tbl.push_back(mk(A, A, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 1, 0, 0));
    tbl.push_back(mk(A, A, A, 3'b100, 3'b111, 1, 1, 0, A, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2, 4, 3'b111, 3'b111, 1, 1, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(A, A, A, 3'b111, 3'b111, 1, 1, 1, A, 1, 1, 0, 0, 1));
    tbl.push_back(mk(A, A, A, 3'b111, 3'b111, 1, 1, 0, A, 1, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_corrected", 32'(corrected_o), 32'h0);
    chk("reset_masked", 32'(masked_id_o), 32'h0);
    chk("reset_fatal", 32'(fatal_o), 32'h0);
    chk("reset_err_cnt", 32'(err_cnt_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].cmp, tbl[i].rdy,
            tbl[i].en, tbl[i].exr, tbl[i].clr);
      chk($sformatf("tbl%0d_result", i), result_o, tbl[i].e_res);
      chk($sformatf("tbl%0d_cmp", i), 32'(comparison_result_o), 32'(tbl[i].e_cmp));
      chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_corrected", i), 32'(corrected_o), 32'(tbl[i].e_corr));
      chk($sformatf("tbl%0d_masked", i), 32'(masked_id_o), 32'(tbl[i].e_mask));
      chk($sformatf("tbl%0d_fatal", i), 32'(fatal_o), 32'(tbl[i].e_fat));
      chk($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt_o), 32'h0);
    end

    // Mask replica 1, then pull reset in the middle of a cycle.
    for (int i = 0; i < THRESH; i++) apply(B, A, A, 3'b111, 3'b111, 1, 1, 0);
    apply(A, A, A, 3'b111, 3'b111, 0, 1, 0);
    chk("seq_masked_before_rst", 32'(masked_id_o), 32'h1);
    chk("seq_corr_before_rst", 32'(corrected_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("seq_masked_in_rst", 32'(masked_id_o), 32'h0);
    chk("seq_corr_in_rst", 32'(corrected_o), 32'h0);
    chk("seq_fatal_in_rst", 32'(fatal_o), 32'h0);
    chk("seq_result_in_rst", result_o, A);
    @(negedge clk);
    rst_n = 1'b1;

    // Streak after reset restarts from zero: three hits must not mask.
    for (int i = 0; i < THRESH - 1; i++) apply(A, A, B, 3'b111, 3'b111, 1, 1, 0);
    apply(A, A, A, 3'b111, 3'b111, 1, 1, 0);
    chk("seq_no_mask_after_rst", 32'(masked_id_o), 32'h0);
    chk("seq_corr_after_rst", 32'(corrected_o), 32'h1);
    apply(A, A, A, 3'b111, 3'b111, 1, 1, 1);

    model_reset();
    run_random(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
